// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The optional performance counters in fetch are enabled by defining FETCH_PERF_CNT_EN.
package fetch_pkg;

    localparam int unsigned INSN_BYTES        = 4;
    localparam int unsigned DWIDTH_DEFAULT    = 32;
    localparam int unsigned AWIDTH_DEFAULT    = 32;
    localparam logic [31:0] FETCH_BASE_ADDR   = 32'h0100_0000;

    typedef enum logic {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    // {pc, insn} pair as handed to decode, at the default widths
    typedef struct packed {
        logic [AWIDTH_DEFAULT-1:0] pc;
        logic [DWIDTH_DEFAULT-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO used by fetch for both the instruction queue and the
// per-request PC tag queue. Clear has priority over push and pop. The owner
// guarantees no overflow or underflow; push and pop together on a full FIFO
// is legal.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    T                mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; count gates every use of it
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues word reads under a credit
// limit, queues returned words in order and hands {pc, insn} to decode.
// A redirect flushes everything and drops responses still in flight.
// Define FETCH_PERF_CNT_EN to add stall_cnt_o / flush_cnt_o counters.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned       DWIDTH    = DWIDTH_DEFAULT,
    parameter int unsigned       AWIDTH    = AWIDTH_DEFAULT,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(FETCH_BASE_ADDR),
    parameter int unsigned       DEPTH     = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    input  logic              redirect_i,
    input  logic [AWIDTH-1:0] redirect_pc_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
`endif
);

    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

    typedef struct packed {
        logic [AWIDTH-1:0] pc;
        logic [DWIDTH-1:0] insn;
    } entry_t;

    fetch_state_e      state_q, state_d;
    logic [AWIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic              active_q;

    logic [CW-1:0]     q_count;
    logic [CW-1:0]     tag_count;
    entry_t            q_head;
    logic [AWIDTH-1:0] tag_head;
    logic [CW:0]       in_use;
    logic [CW-1:0]     in_flight;
    logic              credit_ok;
    logic              req_fire;
    logic              dec_fire;
    logic              rsp_accept;
    logic              unused_pc_bits;

    // The tag FIFO holds one PC per request in flight, so its count is the
    // outstanding-request count; clearing it on redirect zeroes outstanding.
    always_comb begin
        in_use     = {1'b0, q_count} + {1'b0, tag_count};
        credit_ok  = in_use < DEPTH_C;
        imem_req_valid_o = active_q && (state_q == FETCH) && credit_ok && !redirect_i;
        req_fire   = imem_req_valid_o && imem_req_ready_i;
        valid_o    = (q_count != '0) && !redirect_i;
        dec_fire   = valid_o && ready_i;
        rsp_accept = imem_rsp_valid_i && (state_q == FETCH) && !redirect_i;
        in_flight  = tag_count + drop_q;
    end

    assign imem_req_addr_o = fetch_pc_q;
    assign pc_o            = q_head.pc;
    assign insn_o          = q_head.insn;
    assign unused_pc_bits  = ^redirect_pc_i[1:0];

    // Next PC, drop count and FETCH/FLUSH state
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (redirect_i) begin
            fetch_pc_d = {redirect_pc_i[AWIDTH-1:2], 2'b00};
            drop_d     = (imem_rsp_valid_i && (in_flight != '0)) ? in_flight - CW'(1) : in_flight;
            state_d    = (drop_d != '0) ? FLUSH : FETCH;
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + AWIDTH'(INSN_BYTES);
            if (state_q == FLUSH) begin
                if (imem_rsp_valid_i && (drop_q != '0)) drop_d = drop_q - CW'(1);
                if (drop_d == '0) state_d = FETCH;
            end
        end
    end

    // FSM and PC registers; active_q keeps requests off while reset is held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= BASE_ADDR;
            drop_q     <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            active_q   <= 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_i),
        .push      (rsp_accept),
        .push_data ({tag_head, imem_rsp_data_i}),
        .pop       (dec_fire),
        .head      (q_head),
        .count     (q_count)
    );

    fetch_fifo #(.DEPTH(DEPTH), .T(logic [AWIDTH-1:0])) u_tags (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect_i),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_accept),
        .head      (tag_head),
        .count     (tag_count)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counts of decode stalls and redirects
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (valid_o && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (redirect_i && (flush_cnt_q != 32'hFFFF_FFFF))         flush_cnt_d = flush_cnt_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: in-order memory model with variable latency,
// expected PC stream model, scenario tasks plus a randomized run.
module tb_fetch;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    always #5 clk = ~clk;

    fetch #(.DWIDTH(32), .AWIDTH(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .valid_o          (valid_o),
        .ready_i          (ready_i),
        .pc_o             (pc_o),
        .insn_o           (insn_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic tb_ready = 1'b1, tb_req_ready = 1'b1, tb_rsp_en = 1'b1;
    int   lat_min = 1, lat_max = 1;

    logic [31:0] pend_addr [$];
    int          pend_time [$];

    logic [31:0] exp_dec_pc = BASE, exp_req_pc = BASE;
    int issued = 0, decoded = 0, max_use = 0;
    int exp_stall = 0, exp_flush = 0;

    logic        o_req_valid, o_req_fire, o_valid, o_dec_fire, o_rsp;
    logic [31:0] o_req_addr, o_pc, o_insn, o_exp_dec_pc, o_exp_req_pc;
    int          o_cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One clock cycle: drive inputs at the negedge, sample 1 time unit later,
    // advance memory and the expected-stream model, then wait for the next negedge.
    task automatic step(input logic redir, input logic [31:0] tgt);
        int t;
        redirect_i       = redir;
        redirect_pc_i    = tgt;
        ready_i          = tb_ready;
        imem_req_ready_i = tb_req_ready;
        imem_rsp_valid_i = 1'b0;
        o_rsp            = 1'b0;
        if (tb_rsp_en && pend_addr.size() > 0 && pend_time[0] <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(pend_addr.pop_front());
            void'(pend_time.pop_front());
            o_rsp = 1'b1;
        end
        #1;
        o_cyc        = cyc;
        o_req_valid  = imem_req_valid_o;
        o_req_addr   = imem_req_addr_o;
        o_req_fire   = imem_req_valid_o & imem_req_ready_i;
        o_valid      = valid_o;
        o_dec_fire   = valid_o & ready_i;
        o_pc         = pc_o;
        o_insn       = insn_o;
        o_exp_dec_pc = exp_dec_pc;
        o_exp_req_pc = exp_req_pc;
        if (o_req_fire) begin
            t = cyc + int'($urandom_range(lat_max, lat_min));
            if (pend_time.size() > 0 && t < pend_time[$]) t = pend_time[$];
            pend_addr.push_back(o_req_addr);
            pend_time.push_back(t);
            exp_req_pc += 32'd4;
        end
        if (o_dec_fire) exp_dec_pc += 32'd4;
        if (o_valid && !ready_i) exp_stall++;
        if (redir) begin
            exp_dec_pc = {tgt[31:2], 2'b00};
            exp_req_pc = {tgt[31:2], 2'b00};
            issued = 0;
            decoded = 0;
            exp_flush++;
        end else begin
            issued  += int'(o_req_fire);
            decoded += int'(o_dec_fire);
        end
        if (issued - decoded > max_use) max_use = issued - decoded;
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (imem_req_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", imem_req_valid_o); end
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt_o, flush_cnt_o); end
`endif
        @(negedge clk);
        rst = 1'b1;
        cyc++;
    endtask

    task automatic test_stream();
        int first_req = -1, first_dec = -1, ndec = 0;
        tb_ready = 1'b1; tb_req_ready = 1'b1; tb_rsp_en = 1'b1; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'd0);
            if (o_req_fire) begin
                if (first_req < 0) first_req = o_cyc;
                checks++;
                if (o_req_addr !== o_exp_req_pc) begin errors++; $display("[TB] FAIL stream_req_addr: got %h expected %h", o_req_addr, o_exp_req_pc); end
            end
            if (o_dec_fire) begin
                if (first_dec < 0) first_dec = o_cyc;
                ndec++;
                checks++;
                if (o_pc !== o_exp_dec_pc || o_insn !== mem_word(o_exp_dec_pc)) begin errors++; $display("[TB] FAIL stream_decode: got %h/%h expected %h/%h", o_pc, o_insn, o_exp_dec_pc, mem_word(o_exp_dec_pc)); end
            end
        end
        checks++;
        if (first_req < 0 || first_dec - first_req != 2) begin errors++; $display("[TB] FAIL first_latency: got %0d expected 2", first_dec - first_req); end
        checks++;
        if (ndec < 6) begin errors++; $display("[TB] FAIL stream_count: got %0d expected at least 6", ndec); end
    endtask

    task automatic test_backpressure();
        logic        held = 1'b0;
        logic [31:0] held_pc = '0, held_insn = '0;
        int          unstable = 0;
        max_use = 0;
        tb_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'd0);
            if (o_req_fire) begin
                checks++;
                if (o_req_addr !== o_exp_req_pc) begin errors++; $display("[TB] FAIL bp_req_addr: got %h expected %h", o_req_addr, o_exp_req_pc); end
            end
            if (o_valid) begin
                if (!held) begin held = 1'b1; held_pc = o_pc; held_insn = o_insn; end
                else if (o_pc !== held_pc || o_insn !== held_insn) unstable++;
            end
        end
        checks++;
        if (max_use > DEPTH) begin errors++; $display("[TB] FAIL bp_credit: got %0d in use expected at most %0d", max_use, DEPTH); end
        checks++;
        if (issued - decoded != DEPTH) begin errors++; $display("[TB] FAIL bp_fill: got %0d in use expected %0d", issued - decoded, DEPTH); end
        checks++;
        if (o_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_request: got %b expected 0", o_req_valid); end
        checks++;
        if (unstable != 0) begin errors++; $display("[TB] FAIL bp_stable: got %0d changes expected 0", unstable); end
        checks++;
        if (o_valid !== 1'b1 || o_pc !== o_exp_dec_pc || o_insn !== mem_word(o_exp_dec_pc)) begin errors++; $display("[TB] FAIL bp_head: got %b %h/%h expected 1 %h/%h", o_valid, o_pc, o_insn, o_exp_dec_pc, mem_word(o_exp_dec_pc)); end
        tb_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'd0);
            if (o_dec_fire) begin
                checks++;
                if (o_pc !== o_exp_dec_pc || o_insn !== mem_word(o_exp_dec_pc)) begin errors++; $display("[TB] FAIL bp_resume: got %h/%h expected %h/%h", o_pc, o_insn, o_exp_dec_pc, mem_word(o_exp_dec_pc)); end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        int bad = 0;
        tb_ready = 1'b1; tb_req_ready = 1'b1; tb_rsp_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'd0);
            if (o_dec_fire) begin
                checks++;
                if (o_pc !== o_exp_dec_pc || o_insn !== mem_word(o_exp_dec_pc)) begin errors++; $display("[TB] FAIL rdi_drain: got %h/%h expected %h/%h", o_pc, o_insn, o_exp_dec_pc, mem_word(o_exp_dec_pc)); end
            end
        end
        checks++;
        if (pend_addr.size() != DEPTH) begin errors++; $display("[TB] FAIL rdi_inflight: got %0d expected %0d", pend_addr.size(), DEPTH); end
        step(1'b1, 32'h0100_0040);
        checks++;
        if (o_req_valid !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdi_redirect_cycle: got %b/%b expected 0/0", o_req_valid, o_valid); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0);
            if (o_req_valid || o_valid) bad++;
        end
        tb_rsp_en = 1'b1;
        for (int i = 0; i < 10 && pend_addr.size() > 0; i++) begin
            step(1'b0, 32'd0);
            if (o_req_valid || o_valid) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL rdi_flush_quiet: got %0d active cycles expected 0", bad); end
        checks++;
        if (pend_addr.size() != 0) begin errors++; $display("[TB] FAIL rdi_drain_bound: got %0d pending expected 0", pend_addr.size()); end
        step(1'b0, 32'd0);
        checks++;
        if (o_req_valid !== 1'b1 || o_req_addr !== 32'h0100_0040) begin errors++; $display("[TB] FAIL rdi_restart: got %b %h expected 1 01000040", o_req_valid, o_req_addr); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'd0);
            if (o_dec_fire) begin
                checks++;
                if (o_pc !== o_exp_dec_pc || o_insn !== mem_word(o_exp_dec_pc)) begin errors++; $display("[TB] FAIL rdi_decode: got %h/%h expected %h/%h", o_pc, o_insn, o_exp_dec_pc, mem_word(o_exp_dec_pc)); end
            end
        end
    endtask

    task automatic test_redirect_coincident();
        logic found = 1'b0;
        tb_ready = 1'b1; tb_req_ready = 1'b1; tb_rsp_en = 1'b1; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) begin
            if (valid_o && pend_addr.size() > 0 && pend_time[0] <= cyc) break;
            step(1'b0, 32'd0);
        end
        step(1'b1, 32'h0100_0083);
        checks++;
        if (o_rsp !== 1'b1) begin errors++; $display("[TB] FAIL rdc_setup_rsp: got %b expected 1", o_rsp); end
        checks++;
        if (o_valid !== 1'b0 || o_dec_fire !== 1'b0 || o_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdc_forced_low: got %b/%b expected 0/0", o_valid, o_req_valid); end
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b0, 32'd0);
            if (o_dec_fire) begin
                found = 1'b1;
                checks++;
                if (o_pc !== 32'h0100_0080 || o_insn !== mem_word(32'h0100_0080)) begin errors++; $display("[TB] FAIL rdc_first_decode: got %h/%h expected 01000080/%h", o_pc, o_insn, mem_word(32'h0100_0080)); end
            end
        end
        checks++;
        if (!found) begin errors++; $display("[TB] FAIL rdc_timeout: got no decode expected one within 30 cycles"); end
    endtask

    task automatic test_req_stall();
        logic [31:0] rec;
        tb_ready = 1'b1; tb_req_ready = 1'b0; tb_rsp_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'd0);
            if (o_req_valid) break;
        end
        rec = o_req_addr;
        checks++;
        if (o_req_valid !== 1'b1 || rec !== o_exp_req_pc) begin errors++; $display("[TB] FAIL stall_setup: got %b %h expected 1 %h", o_req_valid, rec, o_exp_req_pc); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'd0);
            checks++;
            if (o_req_valid !== 1'b1 || o_req_addr !== rec) begin errors++; $display("[TB] FAIL stall_hold: got %b %h expected 1 %h", o_req_valid, o_req_addr, rec); end
        end
        tb_req_ready = 1'b1;
        step(1'b0, 32'd0);
        checks++;
        if (o_req_fire !== 1'b1 || o_req_addr !== rec) begin errors++; $display("[TB] FAIL stall_accept: got %b %h expected 1 %h", o_req_fire, o_req_addr, rec); end
    endtask

    task automatic test_async_reset();
        logic got_first = 1'b0;
        tb_ready = 1'b1; tb_req_ready = 1'b1; tb_rsp_en = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0);
        #2;
        rst = 1'b0;
        imem_rsp_valid_i = 1'b0;
        #1;
        checks++;
        if (imem_req_valid_o !== 1'b0 || valid_o !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_outputs: got %b/%b expected 0/0", imem_req_valid_o, valid_o); end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin errors++; $display("[TB] FAIL async_reset_counters: got %0d/%0d expected 0/0", stall_cnt_o, flush_cnt_o); end
`endif
        @(negedge clk);
        @(negedge clk);
        pend_addr.delete();
        pend_time.delete();
        exp_dec_pc = BASE; exp_req_pc = BASE;
        issued = 0; decoded = 0; exp_stall = 0; exp_flush = 0;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'd0);
            if (o_req_fire && !got_first) begin
                got_first = 1'b1;
                checks++;
                if (o_req_addr !== 32'h0100_0000) begin errors++; $display("[TB] FAIL async_restart_addr: got %h expected 01000000", o_req_addr); end
            end
            if (o_dec_fire) begin
                checks++;
                if (o_pc !== o_exp_dec_pc || o_insn !== mem_word(o_exp_dec_pc)) begin errors++; $display("[TB] FAIL async_decode: got %h/%h expected %h/%h", o_pc, o_insn, o_exp_dec_pc, mem_word(o_exp_dec_pc)); end
            end
        end
        checks++;
        if (!got_first) begin errors++; $display("[TB] FAIL async_restart_timeout: got no request expected one"); end
    endtask

    task automatic test_random();
        logic        redir;
        logic [31:0] tgt;
        max_use = 0;
        lat_min = 1; lat_max = 3; tb_rsp_en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tb_ready     = ($urandom % 10) < 7;
            tb_req_ready = ($urandom % 10) < 7;
            redir        = ($urandom % 32) == 0;
            tgt          = BASE + 32'(($urandom % 64) * 4) + 32'($urandom % 4);
            step(redir, tgt);
            if (redir) begin
                checks++;
                if (o_valid !== 1'b0 || o_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_redirect_cycle: got %b/%b expected 0/0", o_valid, o_req_valid); end
            end
            if (o_req_fire) begin
                checks++;
                if (o_req_addr !== o_exp_req_pc) begin errors++; $display("[TB] FAIL rnd_req_addr: got %h expected %h", o_req_addr, o_exp_req_pc); end
            end
            if (o_dec_fire) begin
                checks++;
                if (o_pc !== o_exp_dec_pc || o_insn !== mem_word(o_exp_dec_pc)) begin errors++; $display("[TB] FAIL rnd_decode: got %h/%h expected %h/%h", o_pc, o_insn, o_exp_dec_pc, mem_word(o_exp_dec_pc)); end
            end
        end
        checks++;
        if (max_use > DEPTH) begin errors++; $display("[TB] FAIL rnd_credit: got %0d in use expected at most %0d", max_use, DEPTH); end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (stall_cnt_o !== 32'(exp_stall)) begin errors++; $display("[TB] FAIL rnd_stall_cnt: got %0d expected %0d", stall_cnt_o, exp_stall); end
        checks++;
        if (flush_cnt_o !== 32'(exp_flush)) begin errors++; $display("[TB] FAIL rnd_flush_cnt: got %0d expected %0d", flush_cnt_o, exp_flush); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_req_stall();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
